sisc_ifetch: RTL and testbench
==============================

# sisc_ifetch

Instruction fetch unit for the SISC processor: owns the fetch program counter, reads 32-bit instruction words from instruction memory over a req/ack handshake, and presents them on `ir` to the control unit with a valid/take handshake. It is the producing end of the `ir` interface that the processor core consumes. It also handles branch redirects with buffer flush, and stops fetching at HLT.

## Interface
Parameters:
- `AW`, 16, word-address / PC width
- `DW`, 32, instruction width (fixed at 32 for SISC; parameter exists for memory width checks only)

Ports:
- `clk`  in  1  processor clock, rising-edge
- `rst_f`  in  1  asynchronous, active-low reset
- `imem_addr`  out  AW  word address of current read request
- `imem_req`  out  1  read request; held with stable address until acked
- `imem_ack`  in  1  read complete; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  DW  instruction word from memory
- `ir`  out  DW  instruction at buffer head
- `ir_valid`  out  1  `ir` holds a fetched instruction
- `ir_take`  in  1  control consumes `ir` this cycle
- `ir_pc`  out  AW  word address of the instruction in `ir`
- `br_en`  in  1  redirect fetch (taken branch)
- `br_addr`  in  AW  redirect target
- `halted`  out  1  HLT consumed; fetch stopped

## Operation
- Reset (asynchronous, `rst_f`=0): fetch PC=0, state IDLE, buffer empty, `imem_req`=0, `imem_addr`=0, `ir`=32'h00000000 (NOP), `ir_pc`=0, `ir_valid`=0, `halted`=0, stop flag clear.
- FSM states: IDLE, REQ, DRAIN, HALT.
  - IDLE -> REQ when buffer has a free slot and stop flag clear.
  - REQ: `imem_req`=1, `imem_addr`=fetch PC. On `imem_ack`: push `{imem_rdata, fetch PC}`, fetch PC += 1 (wraps modulo 2^AW). Stay in REQ if a slot remains after the push and the word is not HLT; otherwise go to IDLE.
  - DRAIN: entered on `br_en` while in REQ without `imem_ack`. Keep `imem_req`/`imem_addr` asserted until `imem_ack`, discard the data, then go to REQ at the new PC.
  - HALT: entered when `ir_take` pops an HLT word. `halted`=1, `ir_valid`=0, no requests. Exit only by reset.
- HLT detection: `imem_rdata[31:28]==4'hF` at push sets the stop flag, and no further requests are issued.
- Consumption: `ir_take` with `ir_valid`=1 pops the head. `ir_take` with `ir_valid`=0 is ignored.
- Redirect (`br_en`, ignored in HALT):
  - flush the buffer; `ir_valid`=0 next cycle;
  - fetch PC <= `br_addr`;
  - clear the stop flag.
- Simultaneous events:
  - `br_en` + `imem_ack`: drop the data, next request goes to `br_addr`.
  - `br_en` + `ir_take`: flush wins; the pop is a no-op.
  - push + pop in the same cycle: both occur, and occupancy is unchanged.

## Timing
- Memory read is single-cycle at best. Edge E0 raises `imem_req`. If `imem_ack` is high in that cycle, the word is captured at E1 and `ir_valid`=1 after E1.
- First request: first rising edge after `rst_f` deasserts.
- Redirect latency: `br_en` sampled at E0 gives `imem_addr`=`br_addr` after E0 (if no request is outstanding). The earliest valid target instruction appears after E1.
- `imem_addr` changes only at an edge where `imem_ack` was high, or where `imem_req` was low.
- All outputs are registered.

## Configuration
- `IFETCH_PREFETCH_EN` defined: 2-entry buffer. Fetching continues while `ir` is held, giving back-to-back `ir_valid` with single-cycle memory.
- Not defined: 1-entry buffer. A new request is issued only after the head is taken, so there is at least one bubble cycle between instructions. All other behaviour is identical.

## Structure
- `sisc_pkg`: `OP_HLT` (4'hF), `IR_NOP` (32'h0), the fetch FSM state enum, and the default `AW`.
- Sub-module `sisc_ifetch_buf`:
  - 1- or 2-entry FIFO of `{ir, pc}`;
  - ports push, pop, flush, full, empty;
  - depth selected by `IFETCH_PREFETCH_EN`.

## Test plan
- Reset, memory acks every request, words 32'h88100001 / 32'h80211001 at addresses 0 / 1, `ir_take` held high -> `imem_addr` sequence 0,1,2…; `ir` shows 88100001 (`ir_pc`=0), then 80211001 (`ir_pc`=1). With prefetch, `ir_valid` stays high continuously.
- Memory acks 3 cycles after req -> `imem_addr` and `imem_req` stable for all 3 cycles, and `ir_valid` rises the cycle after ack.
- Word at address 2 is 32'hF0000000 -> no request to address 3; after `ir_take` of HLT, `halted`=1 and `ir_valid`=0. A later `br_en` is ignored.
- `br_en`, `br_addr`=16'h0040 during an outstanding un-acked request -> request held until ack, data discarded, next `imem_addr`=0040, and the next `ir_pc`=0040.
- `br_en` and `ir_take` in the same cycle with 2 entries buffered -> `ir_valid`=0 next cycle, and the next `ir` comes from `br_addr`.
- Fetch PC at 16'hFFFF acked -> next `imem_addr`=16'h0000. Reset asserted mid-request -> `imem_req`=0 and `ir`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared constants, buffer depth and fetch FSM states for the SISC fetch unit.
// Latency: none (declarations only).
// Backpressure: none. IFETCH_PREFETCH_EN selects a 2-entry instruction buffer; otherwise it has 1 entry.
package sisc_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;

   localparam logic [3:0]  OP_HLT = 4'hF;
   localparam logic [31:0] IR_NOP = 32'h0000_0000;

`ifdef IFETCH_PREFETCH_EN
   localparam int IFB_DEPTH = 2;
`else
   localparam int IFB_DEPTH = 1;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   // An instruction is HLT when its opcode nibble is all ones.
   function automatic logic is_hlt(input logic [3:0] opcode);
      return opcode == OP_HLT;
   endfunction

endpackage

// File: rtl/sisc_ifetch_if.sv
// sisc_ifetch_if: bundles the instruction-memory bus, the ir handshake and the redirect inputs.
// Latency: none (wiring only).
// Backpressure: imem_ack stalls the fetcher's request; ir_take drains ir.
interface sisc_ifetch_if #(
   parameter int AW = sisc_pkg::AW_DEF,
   parameter int DW = sisc_pkg::DW_DEF
);
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          ir_take;
   logic [AW-1:0] ir_pc;
   logic          br_en;
   logic [AW-1:0] br_addr;
   logic          halted;

   // Fetch-unit side.
   modport master (
      output imem_addr, imem_req, ir, ir_valid, ir_pc, halted,
      input  imem_ack, imem_rdata, ir_take, br_en, br_addr
   );

   // Memory/control side.
   modport slave (
      input  imem_addr, imem_req, ir, ir_valid, ir_pc, halted,
      output imem_ack, imem_rdata, ir_take, br_en, br_addr
   );
endinterface

// File: rtl/sisc_ifetch_buf.sv
// sisc_ifetch_buf: instruction buffer of {ir, pc} pairs. Depth is 2 with IFETCH_PREFETCH_EN, else 1.
// Latency: a push is visible at the head one cycle later. The head is a register, so outputs are registered.
// Backpressure: the caller must not push when full. A flush empties the buffer and overrides push and pop.
module sisc_ifetch_buf
   import sisc_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          push_i,
   input  logic [DW-1:0] push_ir_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [1:0]    cnt_o,
   output logic          head_vld_o,
   output logic [DW-1:0] head_ir_o,
   output logic [AW-1:0] head_pc_o
);

   logic          vld0_q, vld0_d;
   logic [DW-1:0] ir0_q, ir0_d;
   logic [AW-1:0] pc0_q, pc0_d;
`ifdef IFETCH_PREFETCH_EN
   logic          vld1_q, vld1_d;
   logic [DW-1:0] ir1_q, ir1_d;
   logic [AW-1:0] pc1_q, pc1_d;
`endif

   // Next-state logic. The pop is applied first, so a simultaneous push
   // lands in the slot that the pop has just freed.
   always_comb begin
      vld0_d = vld0_q;
      ir0_d  = ir0_q;
      pc0_d  = pc0_q;
`ifdef IFETCH_PREFETCH_EN
      vld1_d = vld1_q;
      ir1_d  = ir1_q;
      pc1_d  = pc1_q;
`endif
      if (flush_i) begin
         vld0_d = 1'b0;
`ifdef IFETCH_PREFETCH_EN
         vld1_d = 1'b0;
`endif
      end else begin
         if (pop_i) begin
`ifdef IFETCH_PREFETCH_EN
            vld0_d = vld1_q;
            ir0_d  = ir1_q;
            pc0_d  = pc1_q;
            vld1_d = 1'b0;
`else
            vld0_d = 1'b0;
`endif
         end
         if (push_i) begin
            if (!vld0_d) begin
               vld0_d = 1'b1;
               ir0_d  = push_ir_i;
               pc0_d  = push_pc_i;
            end
`ifdef IFETCH_PREFETCH_EN
            else begin
               vld1_d = 1'b1;
               ir1_d  = push_ir_i;
               pc1_d  = push_pc_i;
            end
`endif
         end
      end
   end

   // Buffer registers. On reset the head shows a NOP at pc 0.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         vld0_q <= 1'b0;
         ir0_q  <= DW'(IR_NOP);
         pc0_q  <= '0;
`ifdef IFETCH_PREFETCH_EN
         vld1_q <= 1'b0;
         ir1_q  <= DW'(IR_NOP);
         pc1_q  <= '0;
`endif
      end else begin
         vld0_q <= vld0_d;
         ir0_q  <= ir0_d;
         pc0_q  <= pc0_d;
`ifdef IFETCH_PREFETCH_EN
         vld1_q <= vld1_d;
         ir1_q  <= ir1_d;
         pc1_q  <= pc1_d;
`endif
      end
   end

`ifdef IFETCH_PREFETCH_EN
   assign full_o = vld1_q;
   assign cnt_o  = {1'b0, vld0_q} + {1'b0, vld1_q};
`else
   assign full_o = vld0_q;
   assign cnt_o  = {1'b0, vld0_q};
`endif
   assign empty_o    = !vld0_q;
   assign head_vld_o = vld0_q;
   assign head_ir_o  = ir0_q;
   assign head_pc_o  = pc0_q;

endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: owns the fetch PC, reads instruction words over imem req/ack and presents them on ir with valid/take. IFETCH_PREFETCH_EN enables the 2-entry buffer.
// Latency: with a single-cycle memory, ir_valid rises one edge after imem_req. A redirect drives imem_addr one edge after br_en.
// Backpressure: no request is issued while the buffer is full or a HLT is buffered. A request is held with a stable address until imem_ack.
module sisc_ifetch
   import sisc_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_f,
   sisc_ifetch_if.master bus
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          req_q, req_d;
   logic          stop_q, stop_d;
   logic          halted_q, halted_d;

   logic          flush, pop, push, word_hlt, head_hlt, slot_left;
   logic          buf_full, buf_empty, head_vld;
   logic [1:0]    buf_cnt;
   logic [DW-1:0] head_ir;
   logic [AW-1:0] head_pc;

   // A redirect flushes the buffer in every state except HALT.
   // The flush overrides a pop issued in the same cycle.
   assign flush     = bus.br_en && (state_q != ST_HALT);
   assign pop       = bus.ir_take && head_vld && !flush;
   assign push      = (state_q == ST_REQ) && bus.imem_ack && !flush;
   assign word_hlt  = is_hlt(bus.imem_rdata[DW-1 -: 4]);
   assign head_hlt  = is_hlt(head_ir[DW-1 -: 4]);
   assign slot_left = (buf_cnt + 2'd1 - {1'b0, pop}) < 2'(IFB_DEPTH);

   sisc_ifetch_buf #(.AW(AW), .DW(DW)) u_buf (
      .clk       (clk),
      .rst_f     (rst_f),
      .push_i    (push),
      .push_ir_i (bus.imem_rdata),
      .push_pc_i (addr_q),
      .pop_i     (pop),
      .flush_i   (flush),
      .full_o    (buf_full),
      .empty_o   (buf_empty),
      .cnt_o     (buf_cnt),
      .head_vld_o(head_vld),
      .head_ir_o (head_ir),
      .head_pc_o (head_pc)
   );

   // Next fetch state, fetch PC and stop flag. The bus outputs are derived
   // from the next state so that they leave the flops directly.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stop_d  = stop_q;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               pc_d    = bus.br_addr;
               stop_d  = 1'b0;
               state_d = ST_REQ;
            end else if (!buf_full && !stop_q) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush) begin
               pc_d    = bus.br_addr;
               stop_d  = 1'b0;
               // If the request has not been acked yet, it must finish before the target is fetched.
               state_d = bus.imem_ack ? ST_REQ : ST_DRAIN;
            end else if (bus.imem_ack) begin
               pc_d = pc_q + AW'(1);
               if (word_hlt) begin
                  stop_d = 1'b1;
               end
               state_d = (slot_left && !word_hlt) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (flush) begin
               pc_d   = bus.br_addr;
               stop_d = 1'b0;
            end
            if (bus.imem_ack) begin
               state_d = ST_REQ;
            end
         end
         default: ;
      endcase
      if (pop && head_hlt) begin
         state_d = ST_HALT;
      end
   end

   // Registered bus outputs. During DRAIN the address of the stale request is held.
   always_comb begin
      req_d    = (state_d == ST_REQ) || (state_d == ST_DRAIN);
      addr_d   = (state_d == ST_REQ) ? pc_d : addr_q;
      halted_d = (state_d == ST_HALT);
   end

   // Fetch state registers.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         stop_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         stop_q   <= stop_d;
         halted_q <= halted_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.ir        = head_ir;
   assign bus.ir_pc     = head_pc;
   assign bus.ir_valid  = head_vld;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: directed bench for sisc_ifetch with a memory responder of programmable latency.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: ir_take is driven directly by the directed steps.
module tb_sisc_ifetch;

   logic clk;
   logic rst_f;
   int   lat;
   int   checks;
   int   errors;

   sisc_ifetch_if #(.AW(16), .DW(32)) bus ();

   sisc_ifetch #(.AW(16), .DW(32)) dut (
      .clk  (clk),
      .rst_f(rst_f),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 32'h8810_0001;
         16'h0001: return 32'h8021_1001;
         16'h0002: return 32'hF000_0000;
         default:  return {16'h1000, a};
      endcase
   endfunction

   // Memory responder: acks a request after it has been pending for lat cycles.
   initial begin : mem_resp
      int waited;
      waited = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.imem_ack) waited = 0;
         if (bus.imem_req) begin
            if (waited >= lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_word(bus.imem_addr);
            end else begin
               bus.imem_ack = 1'b0;
               waited++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            waited = 0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chka(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_f       = 1'b0;
      bus.ir_take = 1'b0;
      bus.br_en   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_f = 1'b1;
   endtask

   initial begin : main
      int n;
      checks      = 0;
      errors      = 0;
      lat         = 0;
      rst_f       = 1'b1;
      bus.ir_take = 1'b0;
      bus.br_en   = 1'b0;
      bus.br_addr = '0;
      #2 rst_f = 1'b0;
      #1;
      chk1("rst_req", bus.imem_req, 1'b0);
      chka("rst_addr", bus.imem_addr, 16'h0000);
      chkw("rst_ir", bus.ir, 32'h0000_0000);
      chka("rst_ir_pc", bus.ir_pc, 16'h0000);
      chk1("rst_valid", bus.ir_valid, 1'b0);
      chk1("rst_halted", bus.halted, 1'b0);

      // Stream from address 0 with ir_take held high. The word at address 2 is HLT.
      @(negedge clk);
      @(negedge clk);
      rst_f       = 1'b1;
      bus.ir_take = 1'b1;
      step();
      chk1("t1_req0", bus.imem_req, 1'b1);
      chka("t1_addr0", bus.imem_addr, 16'h0000);
      chk1("t1_nvalid0", bus.ir_valid, 1'b0);
      step();
      chk1("t1_valid_a", bus.ir_valid, 1'b1);
      chkw("t1_ir_a", bus.ir, 32'h8810_0001);
      chka("t1_pc_a", bus.ir_pc, 16'h0000);
`ifdef IFETCH_PREFETCH_EN
      chk1("t1_req1", bus.imem_req, 1'b1);
      chka("t1_addr1", bus.imem_addr, 16'h0001);
      step();
      chk1("t1_valid_b", bus.ir_valid, 1'b1);
      chkw("t1_ir_b", bus.ir, 32'h8021_1001);
      chka("t1_pc_b", bus.ir_pc, 16'h0001);
      chka("t1_addr2", bus.imem_addr, 16'h0002);
      step();
      chk1("t1_valid_h", bus.ir_valid, 1'b1);
      chkw("t1_ir_h", bus.ir, 32'hF000_0000);
      chka("t1_pc_h", bus.ir_pc, 16'h0002);
      chk1("t1_req_stop", bus.imem_req, 1'b0);
`else
      chk1("t1_req_idle", bus.imem_req, 1'b0);
      step();
      chk1("t1_bubble", bus.ir_valid, 1'b0);
      step();
      chk1("t1_req1", bus.imem_req, 1'b1);
      chka("t1_addr1", bus.imem_addr, 16'h0001);
      step();
      chk1("t1_valid_b", bus.ir_valid, 1'b1);
      chkw("t1_ir_b", bus.ir, 32'h8021_1001);
      chka("t1_pc_b", bus.ir_pc, 16'h0001);
      step();
      chk1("t1_bubble2", bus.ir_valid, 1'b0);
      step();
      chka("t1_addr2", bus.imem_addr, 16'h0002);
      step();
      chk1("t1_valid_h", bus.ir_valid, 1'b1);
      chkw("t1_ir_h", bus.ir, 32'hF000_0000);
      chka("t1_pc_h", bus.ir_pc, 16'h0002);
      chk1("t1_req_stop", bus.imem_req, 1'b0);
`endif
      step();
      chk1("t1_halted", bus.halted, 1'b1);
      chk1("t1_halt_nvalid", bus.ir_valid, 1'b0);
      chk1("t1_halt_noreq", bus.imem_req, 1'b0);
      step();
      chk1("t1_halt_noreq2", bus.imem_req, 1'b0);
      bus.ir_take = 1'b0;
      bus.br_en   = 1'b1;
      bus.br_addr = 16'h0040;
      step();
      bus.br_en = 1'b0;
      chk1("t1_br_ign_halted", bus.halted, 1'b1);
      chk1("t1_br_ign_req", bus.imem_req, 1'b0);
      step();
      chk1("t1_br_ign_req2", bus.imem_req, 1'b0);
      chk1("t1_br_ign_valid", bus.ir_valid, 1'b0);

      // Memory with a 3-cycle ack latency.
      lat = 3;
      do_reset();
      step();
      chk1("t2_req", bus.imem_req, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("t2_req_hold", bus.imem_req, 1'b1);
         chka("t2_addr_hold", bus.imem_addr, 16'h0000);
         chk1("t2_nvalid", bus.ir_valid, 1'b0);
      end
      step();
      chk1("t2_valid", bus.ir_valid, 1'b1);
      chkw("t2_ir", bus.ir, 32'h8810_0001);

      // Redirect while a request is still waiting for its ack.
      do_reset();
      step();
      chka("t3_addr0", bus.imem_addr, 16'h0000);
      step();
      bus.br_en   = 1'b1;
      bus.br_addr = 16'h0040;
      step();
      bus.br_en = 1'b0;
      chk1("t3_drain_req", bus.imem_req, 1'b1);
      chka("t3_drain_addr", bus.imem_addr, 16'h0000);
      chk1("t3_drain_nvalid", bus.ir_valid, 1'b0);
      step();
      chka("t3_drain_addr2", bus.imem_addr, 16'h0000);
      step();
      chk1("t3_tgt_req", bus.imem_req, 1'b1);
      chka("t3_tgt_addr", bus.imem_addr, 16'h0040);
      chk1("t3_discard", bus.ir_valid, 1'b0);
      lat = 0;
      step();
      chk1("t3_valid", bus.ir_valid, 1'b1);
      chkw("t3_ir", bus.ir, 32'h1000_0040);
      chka("t3_pc", bus.ir_pc, 16'h0040);

      // Redirect and take in the same cycle with the buffer full.
      step();
      chk1("t4_full_valid", bus.ir_valid, 1'b1);
      chkw("t4_full_ir", bus.ir, 32'h1000_0040);
      chk1("t4_full_noreq", bus.imem_req, 1'b0);
      bus.br_en   = 1'b1;
      bus.br_addr = 16'h0100;
      bus.ir_take = 1'b1;
      step();
      bus.br_en   = 1'b0;
      bus.ir_take = 1'b0;
      chk1("t4_flush_nvalid", bus.ir_valid, 1'b0);
      chk1("t4_req", bus.imem_req, 1'b1);
      chka("t4_addr", bus.imem_addr, 16'h0100);
      step();
      chk1("t4_valid", bus.ir_valid, 1'b1);
      chkw("t4_ir", bus.ir, 32'h1000_0100);
      chka("t4_pc", bus.ir_pc, 16'h0100);

      // The fetch PC wraps from FFFF to 0000.
      bus.br_en   = 1'b1;
      bus.br_addr = 16'hFFFF;
      bus.ir_take = 1'b1;
      step();
      bus.br_en   = 1'b0;
      bus.ir_take = 1'b0;
      chk1("t5_nvalid", bus.ir_valid, 1'b0);
      chka("t5_addr_ffff", bus.imem_addr, 16'hFFFF);
      step();
      chk1("t5_valid", bus.ir_valid, 1'b1);
      chkw("t5_ir", bus.ir, 32'h1000_FFFF);
      chka("t5_pc", bus.ir_pc, 16'hFFFF);
      bus.ir_take = 1'b1;
      n = 0;
      while (!bus.imem_req && n < 4) begin
         step();
         n++;
      end
      chk1("t5_req_wrap", bus.imem_req, 1'b1);
      chka("t5_addr_wrap", bus.imem_addr, 16'h0000);

      // Reset asserted mid-request takes effect without a clock edge.
      chk1("t6_pre_ir_nz", bus.ir != 32'h0, 1'b1);
      rst_f       = 1'b0;
      bus.ir_take = 1'b0;
      #1;
      chk1("t6_req", bus.imem_req, 1'b0);
      chkw("t6_ir", bus.ir, 32'h0000_0000);
      chka("t6_ir_pc", bus.ir_pc, 16'h0000);
      chka("t6_addr", bus.imem_addr, 16'h0000);
      chk1("t6_valid", bus.ir_valid, 1'b0);
      @(negedge clk);
      rst_f = 1'b1;
      step();
      chk1("t6_restart_req", bus.imem_req, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
